// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts CUT responses into a MISR during a run, then
// holds a registered PASS/FAIL verdict against the golden signature and capture count.
module bist_response_analyzer #(
    parameter int unsigned  W         = 16,
    parameter logic [W-1:0] POLY      = W'(16'h1021),
    parameter logic [W-1:0] SEED      = W'(16'h0001),
    parameter logic [W-1:0] GOLDEN    = W'(16'h0000),
    parameter int unsigned  EXP_COUNT = 90,
    parameter int unsigned  CW        = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          RUNNING,
    input  logic          EN,
    input  logic          BIST_END,
    input  logic [W-1:0]  DATA_IN,
    output logic [W-1:0]  SIGNATURE,
    output logic [CW-1:0] COUNT,
    output logic          DONE,
    output logic          PASS,
    output logic          FAIL
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_COMPARE, S_DONE} state_t;

    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] COUNT_EXP = CW'(EXP_COUNT);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  misr_nxt;
    logic [CW-1:0] count_nxt;
    logic          verdict;
    logic          verdict_nxt;
    logic          done_nxt;
    logic          pass_nxt;
    logic          fail_nxt;

    function automatic logic [W-1:0] misr_step(input logic [W-1:0] cur, input logic [W-1:0] din);
        return {cur[W-2:0], 1'b0} ^ (cur[W-1] ? POLY : '0) ^ din;
    endfunction

    // Capture counter sticks at its maximum rather than wrapping
    function automatic logic [CW-1:0] count_inc(input logic [CW-1:0] c);
        return (c == COUNT_MAX) ? c : c + CW'(1);
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (RUNNING)  state_nxt = S_CAPTURE;
            S_CAPTURE: if (BIST_END) state_nxt = S_COMPARE;
            S_COMPARE:               state_nxt = S_DONE;
            S_DONE:    if (RUNNING)  state_nxt = S_CAPTURE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Datapath and verdict next values; DONE/PASS/FAIL are set one edge after entering S_DONE
    always_comb begin
        misr_nxt    = SIGNATURE;
        count_nxt   = COUNT;
        verdict_nxt = verdict;
        done_nxt    = 1'b0;
        pass_nxt    = 1'b0;
        fail_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (RUNNING) begin
                    misr_nxt  = EN ? misr_step(SEED, DATA_IN) : SEED;
                    count_nxt = EN ? CW'(1) : '0;
                end
            end
            S_CAPTURE: begin
                if (!BIST_END && RUNNING && EN) begin
                    misr_nxt  = misr_step(SIGNATURE, DATA_IN);
                    count_nxt = count_inc(COUNT);
                end
            end
            S_COMPARE: begin
                verdict_nxt = (SIGNATURE == GOLDEN) && (COUNT == COUNT_EXP);
            end
            S_DONE: begin
                if (RUNNING) begin
                    misr_nxt    = SEED;
                    count_nxt   = '0;
                    verdict_nxt = 1'b0;
                end else begin
                    done_nxt = 1'b1;
                    pass_nxt = verdict;
                    fail_nxt = !verdict;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SIGNATURE <= SEED;
            COUNT     <= '0;
            verdict   <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL      <= 1'b0;
        end else begin
            SIGNATURE <= misr_nxt;
            COUNT     <= count_nxt;
            verdict   <= verdict_nxt;
            DONE      <= done_nxt;
            PASS      <= pass_nxt;
            FAIL      <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: a default instance and a SEED=0 instance share stimulus;
// per-cycle expectations are queued when driven and compared after the clock edge.
module tb_bist_response_analyzer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        running;
    logic        en;
    logic        bist_end;
    logic [15:0] data_in;

    logic [15:0] sig_d, sig_z;
    logic [7:0]  cnt_d, cnt_z;
    logic        done_d, pass_d, fail_d;
    logic        done_z, pass_z, fail_z;

    always #5 clk = ~clk;

    bist_response_analyzer u_def (
        .CLK(clk), .RESET(rst), .RUNNING(running), .EN(en), .BIST_END(bist_end),
        .DATA_IN(data_in), .SIGNATURE(sig_d), .COUNT(cnt_d), .DONE(done_d),
        .PASS(pass_d), .FAIL(fail_d)
    );

    bist_response_analyzer #(.SEED(16'h0000)) u_z (
        .CLK(clk), .RESET(rst), .RUNNING(running), .EN(en), .BIST_END(bist_end),
        .DATA_IN(data_in), .SIGNATURE(sig_z), .COUNT(cnt_z), .DONE(done_z),
        .PASS(pass_z), .FAIL(fail_z)
    );

    typedef struct {
        string       tag;
        bit          inst;   // 0 = default instance, 1 = SEED=0 instance
        logic [15:0] sig;
        logic [7:0]  cnt;
        logic        done;
        logic        pass;
        logic        fail;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [15:0] sig;
        logic [7:0]  cnt;
    } vec_t;

    exp_t sb[$];
    vec_t tab[16];
    int   checks = 0;
    int   errors = 0;

    // Reference view of both instances
    logic [15:0] m_d, m_z;
    int unsigned m_cnt;
    logic        m_done, m_pd, m_fd, m_pz, m_fz;

    function automatic logic [15:0] misr_ref(input logic [15:0] m, input logic [15:0] d);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    task automatic push_one(input string tag, input bit inst);
        if (inst) sb.push_back('{tag, 1'b1, m_z, 8'(m_cnt), m_done, m_pz, m_fz});
        else      sb.push_back('{tag, 1'b0, m_d, 8'(m_cnt), m_done, m_pd, m_fd});
    endtask

    task automatic push_model(input string tag);
        push_one(tag, 1'b0);
        push_one(tag, 1'b1);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [15:0] s;
        logic [7:0]  c;
        logic        dn, p, f;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst) begin s = sig_z; c = cnt_z; dn = done_z; p = pass_z; f = fail_z; end
            else        begin s = sig_d; c = cnt_d; dn = done_d; p = pass_d; f = fail_d; end
            checks++;
            if (s !== e.sig || c !== e.cnt || dn !== e.done || p !== e.pass || f !== e.fail) begin
                errors++;
                $display("FAIL %s[%s] @%0t: got sig=%h cnt=%0d done=%b pass=%b fail=%b, expected sig=%h cnt=%0d done=%b pass=%b fail=%b",
                         e.tag, e.inst ? "seed0" : "dflt", $time, s, c, dn, p, f,
                         e.sig, e.cnt, e.done, e.pass, e.fail);
            end
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic b, input logic [15:0] d);
        running  = r;
        en       = e;
        bist_end = b;
        data_in  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_d = 16'h0001; m_z = 16'h0000; m_cnt = 0;
        m_done = 1'b0; m_pd = 1'b0; m_fd = 1'b0; m_pz = 1'b0; m_fz = 1'b0;
    endtask

    task automatic capture(input logic [15:0] d, input string tag);
        m_d = misr_ref(m_d, d);
        m_z = misr_ref(m_z, d);
        if (m_cnt < 255) m_cnt++;
        drive(1'b1, 1'b1, 1'b0, d);
        push_model(tag);
        step();
        check_sb();
    endtask

    task automatic hold(input string tag);
        drive(1'b1, 1'b0, 1'b0, 16'($urandom));
        push_model(tag);
        step();
        check_sb();
    endtask

    // From DONE: RUNNING reloads seed and clears count/verdict; this cycle's EN is dropped
    task automatic restart(input string tag);
        drive(1'b1, 1'b1, 1'b0, 16'hFFFF);
        model_reset();
        push_model(tag);
        step();
        check_sb();
    endtask

    // BIST_END (with RUNNING/EN also high) then the two-edge verdict latency and hold
    task automatic finish_run(input logic pz, input string tag);
        drive(1'b1, 1'b1, 1'b1, 16'hABCD);
        push_model({tag, "_end"});
        step(); check_sb();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        push_model({tag, "_cmp"});
        step(); check_sb();
        m_done = 1'b1;
        m_pz = pz;
        m_fz = !pz;
        m_pd = (m_d == 16'h0000) && (m_cnt == 90);
        m_fd = !m_pd;
        push_model({tag, "_verdict"});
        step(); check_sb();
        drive(1'b0, 1'b1, 1'b0, 16'h5555);
        push_model({tag, "_hold"});
        step(); check_sb();
    endtask

    // Async reset asserted between clock edges
    task automatic mid_reset(input string tag);
        drive(1'b1, 1'b1, 1'b0, 16'($urandom));
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        push_model({tag, "_async"});
        check_sb();
        step();
        push_model({tag, "_held"});
        check_sb();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no $finish by %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 15; i++) tab[i] = '{16'h0000, 16'(32'h2 << i), 8'(i + 1)};
        tab[15] = '{16'h0000, 16'h1021, 8'd16};

        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #1 rst = 1'b1;
        #1;
        model_reset();
        push_model("reset");
        check_sb();
        step();
        rst = 1'b0;

        // Test 1: default seed, zero data, 16 captures walking the seed bit into the feedback
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 1'b0, tab[i].data);
            m_d = misr_ref(m_d, tab[i].data);
            m_z = misr_ref(m_z, tab[i].data);
            m_cnt++;
            sb.push_back('{"t1_table", 1'b0, tab[i].sig, tab[i].cnt, 1'b0, 1'b0, 1'b0});
            push_one("t1_seed0", 1'b1);
            step();
            check_sb();
        end
        finish_run(1'b0, "t1");

        // Test 2 (via restart): 90 zero captures with hold cycles interleaved
        restart("t2_restart");
        for (int i = 1; i <= 90; i++) begin
            capture(16'h0000, "t2_cap");
            if (i == 10 || i == 50) hold("t2_hold");
        end
        finish_run(1'b1, "t2");

        // Test 3a: single bit flip on capture 40
        restart("t3a_restart");
        for (int i = 1; i <= 90; i++) capture((i == 40) ? 16'h0001 : 16'h0000, "t3a_cap");
        finish_run(1'b0, "t3a");

        // Test 3b: one capture short
        restart("t3b_restart");
        for (int i = 1; i <= 89; i++) capture(16'h0000, "t3b_cap");
        finish_run(1'b0, "t3b");

        // Test 4: async reset after 30 random captures, then a clean run
        restart("t4_restart");
        for (int i = 1; i <= 30; i++) capture(16'($urandom), "t4_cap");
        mid_reset("t4_rst");
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        push_model("t4_idle_end");
        step(); check_sb();
        drive(1'b0, 1'b1, 1'b0, 16'h1234);
        push_model("t4_idle_en");
        step(); check_sb();
        hold("t4_enter");
        for (int i = 1; i <= 90; i++) capture(16'h0000, "t4_cap2");
        finish_run(1'b1, "t4");

        // Counter saturation
        restart("sat_restart");
        for (int i = 1; i <= 260; i++) capture(16'h0000, "sat_cap");
        finish_run(1'b0, "sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
